// File: rtl/rotator_iq_pkg.sv
// rtl/rotator_iq_pkg.sv - shared width, rounding and saturation helpers for the I/Q rotator
package rotator_iq_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_WAVE_WIDTH = 8;

    // Full-precision product of one data sample and one Q1.(ww-1) wave sample.
    function automatic int prod_width(input int dw, input int ww);
        return dw + ww;
    endfunction

    // One extra bit so the sum or difference of two products never wraps.
    function automatic int sum_width(input int dw, input int ww);
        return dw + ww + 1;
    endfunction

    // Half an output LSB once the Q1.(ww-1) scaling is shifted out.
    function automatic int round_offset(input int ww);
        return 1 << (ww - 2);
    endfunction

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/rotator_round_sat.sv
// rtl/rotator_round_sat.sv - round-half-up, rescale and saturate a wide rotator sum
module rotator_round_sat
    import rotator_iq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WAVE_WIDTH = DEF_WAVE_WIDTH,
    parameter int SUM_WIDTH  = sum_width(DATA_WIDTH, WAVE_WIDTH)
) (
    input  logic signed [SUM_WIDTH-1:0]  sum,
    output logic signed [DATA_WIDTH-1:0] data,
    output logic                         clamp
);

    // One guard bit above the sum keeps the rounding add safe for any parameter choice.
    localparam int RND_W = SUM_WIDTH + 1;
    localparam logic signed [RND_W-1:0] ROUND_OFS = RND_W'(round_offset(WAVE_WIDTH));
    localparam logic signed [RND_W-1:0] SAT_HI    = RND_W'(sat_max(DATA_WIDTH));
    localparam logic signed [RND_W-1:0] SAT_LO    = RND_W'(sat_min(DATA_WIDTH));

    logic signed [RND_W-1:0] rounded;
    logic signed [RND_W-1:0] shifted;

    always_comb begin
        rounded = RND_W'(sum) + ROUND_OFS;
        shifted = rounded >>> (WAVE_WIDTH - 1);
        data    = shifted[DATA_WIDTH-1:0];
        clamp   = 1'b0;
        if (shifted > SAT_HI) begin
            data  = SAT_HI[DATA_WIDTH-1:0];
            clamp = 1'b1;
        end else if (shifted < SAT_LO) begin
            data  = SAT_LO[DATA_WIDTH-1:0];
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/rotator_iq.sv
// rtl/rotator_iq.sv - 3-stage complex rotator / de-rotator with sticky saturation flag
module rotator_iq
    import rotator_iq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WAVE_WIDTH = DEF_WAVE_WIDTH
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_dataI,
    input  logic signed [DATA_WIDTH-1:0] i_dataQ,
    input  logic signed [WAVE_WIDTH-1:0] i_dataSin,
    input  logic signed [WAVE_WIDTH-1:0] i_dataCos,
    input  logic                         i_conj,
    input  logic                         i_clrSat,
    output logic                         o_valid,
    output logic signed [DATA_WIDTH-1:0] o_dataI,
    output logic signed [DATA_WIDTH-1:0] o_dataQ,
    output logic                         o_sat
);

    localparam int PROD_W = prod_width(DATA_WIDTH, WAVE_WIDTH);
    localparam int SUM_W  = sum_width(DATA_WIDTH, WAVE_WIDTH);

    logic                         s1_valid;
    logic                         s1_conj;
    logic signed [DATA_WIDTH-1:0] s1_i;
    logic signed [DATA_WIDTH-1:0] s1_q;
    logic signed [WAVE_WIDTH-1:0] s1_sin;
    logic signed [WAVE_WIDTH-1:0] s1_cos;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_conj  <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_sin   <= '0;
            s1_cos   <= '0;
        end else if (i_enable) begin
            s1_valid <= i_valid;
            s1_conj  <= i_conj;
            s1_i     <= i_dataI;
            s1_q     <= i_dataQ;
            s1_sin   <= i_dataSin;
            s1_cos   <= i_dataCos;
        end
    end

    logic signed [PROD_W-1:0] p_icos;
    logic signed [PROD_W-1:0] p_qsin;
    logic signed [PROD_W-1:0] p_isin;
    logic signed [PROD_W-1:0] p_qcos;

    // Operands are sign-extended to product width first so -128 * -128 stays exact.
    always_comb begin
        p_icos = PROD_W'(s1_i) * PROD_W'(s1_cos);
        p_qsin = PROD_W'(s1_q) * PROD_W'(s1_sin);
        p_isin = PROD_W'(s1_i) * PROD_W'(s1_sin);
        p_qcos = PROD_W'(s1_q) * PROD_W'(s1_cos);
    end

    logic                     s2_valid;
    logic                     s2_conj;
    logic signed [PROD_W-1:0] s2_icos;
    logic signed [PROD_W-1:0] s2_qsin;
    logic signed [PROD_W-1:0] s2_isin;
    logic signed [PROD_W-1:0] s2_qcos;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_conj  <= 1'b0;
            s2_icos  <= '0;
            s2_qsin  <= '0;
            s2_isin  <= '0;
            s2_qcos  <= '0;
        end else if (i_enable) begin
            s2_valid <= s1_valid;
            s2_conj  <= s1_conj;
            s2_icos  <= p_icos;
            s2_qsin  <= p_qsin;
            s2_isin  <= p_isin;
            s2_qcos  <= p_qcos;
        end
    end

    logic signed [SUM_W-1:0] e_icos;
    logic signed [SUM_W-1:0] e_qsin;
    logic signed [SUM_W-1:0] e_isin;
    logic signed [SUM_W-1:0] e_qcos;
    logic signed [SUM_W-1:0] sum_i;
    logic signed [SUM_W-1:0] sum_q;

    // Conjugation negates sin here, at sum width, where -(-128 * x) cannot overflow.
    always_comb begin
        e_icos = SUM_W'(s2_icos);
        e_qsin = SUM_W'(s2_qsin);
        e_isin = SUM_W'(s2_isin);
        e_qcos = SUM_W'(s2_qcos);
        if (s2_conj) begin
            sum_i = e_icos + e_qsin;
            sum_q = e_qcos - e_isin;
        end else begin
            sum_i = e_icos - e_qsin;
            sum_q = e_isin + e_qcos;
        end
    end

    logic signed [DATA_WIDTH-1:0] rs_i;
    logic signed [DATA_WIDTH-1:0] rs_q;
    logic                         clamp_i;
    logic                         clamp_q;

    rotator_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .WAVE_WIDTH (WAVE_WIDTH),
        .SUM_WIDTH  (SUM_W)
    ) u_round_i (
        .sum   (sum_i),
        .data  (rs_i),
        .clamp (clamp_i)
    );

    rotator_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .WAVE_WIDTH (WAVE_WIDTH),
        .SUM_WIDTH  (SUM_W)
    ) u_round_q (
        .sum   (sum_q),
        .data  (rs_q),
        .clamp (clamp_q)
    );

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_dataI <= '0;
            o_dataQ <= '0;
        end else if (i_enable) begin
            o_valid <= s2_valid;
            o_dataI <= rs_i;
            o_dataQ <= rs_q;
        end
    end

    // Flag rises together with the clamped sample; a same-cycle clear loses to it.
    logic sat_set;

    always_comb begin
        sat_set = i_enable && s2_valid && (clamp_i || clamp_q);
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_sat <= 1'b0;
        end else if (sat_set) begin
            o_sat <= 1'b1;
        end else if (i_clrSat) begin
            o_sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotator_iq.sv
// tb/tb_rotator_iq.sv - scoreboard bench for rotator_iq
module tb_rotator_iq;

    logic              clock = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic              i_valid;
    logic signed [7:0] i_dataI;
    logic signed [7:0] i_dataQ;
    logic signed [7:0] i_dataSin;
    logic signed [7:0] i_dataCos;
    logic              i_conj;
    logic              i_clrSat;
    logic              o_valid;
    logic signed [7:0] o_dataI;
    logic signed [7:0] o_dataQ;
    logic              o_sat;

    rotator_iq #(.DATA_WIDTH(8), .WAVE_WIDTH(8)) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_valid   (i_valid),
        .i_dataI   (i_dataI),
        .i_dataQ   (i_dataQ),
        .i_dataSin (i_dataSin),
        .i_dataCos (i_dataCos),
        .i_conj    (i_conj),
        .i_clrSat  (i_clrSat),
        .o_valid   (o_valid),
        .o_dataI   (o_dataI),
        .o_dataQ   (o_dataQ),
        .o_sat     (o_sat)
    );

    always #5 clock = ~clock;

    typedef struct {
        int i;
        int q;
        bit clamp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   sin_tab[64];
    int   cos_tab[64];

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    function automatic int rnd(input int v, output bit cl);
        int r;
        r  = $rtoi($floor((real'(v) + 64.0) / 128.0));
        cl = 1'b0;
        if (r > 127) begin
            r  = 127;
            cl = 1'b1;
        end else if (r < -128) begin
            r  = -128;
            cl = 1'b1;
        end
        return r;
    endfunction

    function automatic void model(input int i, input int q, input int s, input int c,
                                  input bit conj, output int oi, output int oq, output bit cl);
        int sn;
        bit ci;
        bit cq;
        sn = conj ? -s : s;
        oi = rnd(i * c - q * sn, ci);
        oq = rnd(i * sn + q * c, cq);
        cl = ci | cq;
    endfunction

    // Presents one cycle of inputs; a captured valid sample queues its expected output.
    task automatic drive(input int i, input int q, input int s, input int c,
                         input bit conj, input bit valid, input bit en, input bit clr,
                         input int ei, input int eq, input bit ecl);
        logic              pv;
        logic signed [7:0] pi;
        logic signed [7:0] pq;
        exp_t              x;
        i_dataI   = 8'(i);
        i_dataQ   = 8'(q);
        i_dataSin = 8'(s);
        i_dataCos = 8'(c);
        i_conj    = conj;
        i_valid   = valid;
        i_enable  = en;
        i_clrSat  = clr;
        pv = o_valid;
        pi = o_dataI;
        pq = o_dataQ;
        if (en && valid) begin
            x.i = ei;
            x.q = eq;
            x.clamp = ecl;
            sb.push_back(x);
        end
        @(posedge clock);
        #1;
        if (!en) chk("stall_hold", int'({o_valid, o_dataI, o_dataQ}), int'({pv, pi, pq}));
        i_clrSat = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!i_reset && o_valid && i_enable) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got I=%0d Q=%0d required no output",
                             o_dataI, o_dataQ);
                end else begin
                    e = sb.pop_front();
                    chk("out_I", int'(o_dataI), e.i);
                    chk("out_Q", int'(o_dataQ), e.q);
                    if (e.clamp) chk("out_sat", int'(o_sat), 1);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int ri;
        int rq;
        int rs;
        int rc;
        int oi;
        int oq;
        int idx;
        bit rconj;
        bit rv;
        bit ren;
        bit cl;

        for (int k = 0; k < 64; k++) begin
            sin_tab[k] = int'(127.0 * $sin(6.283185307179586 * k / 64.0));
            cos_tab[k] = int'(127.0 * $cos(6.283185307179586 * k / 64.0));
        end

        i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_conj = 1'b0; i_clrSat = 1'b0;
        i_dataI = '0; i_dataQ = '0; i_dataSin = '0; i_dataCos = '0;
        #12;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_I", int'(o_dataI), 0);
        chk("rst_Q", int'(o_dataQ), 0);
        chk("rst_sat", int'(o_sat), 0);
        @(posedge clock);
        #1;
        i_reset = 1'b0;

        // identity with latency
        drive(100, 0, 0, 127, 1'b0, 1'b1, 1'b1, 1'b0, 99, 0, 1'b0);
        drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("lat_valid_c2", int'(o_valid), 0);
        drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("lat_valid_c3", int'(o_valid), 1);
        chk("ident_sat", int'(o_sat), 0);
        idle(2);

        // conjugate back-to-back
        drive(0, 64, 127, 0, 1'b0, 1'b1, 1'b1, 1'b0, -63, 0, 1'b0);
        drive(0, 64, 127, 0, 1'b1, 1'b1, 1'b1, 1'b0, 64, 0, 1'b0);
        idle(4);

        // saturation: sticky, clear, set-wins, clear while stalled
        drive(127, 127, -127, 127, 1'b0, 1'b1, 1'b1, 1'b0, 127, 0, 1'b1);
        drive(100, 0, 0, 127, 1'b0, 1'b1, 1'b1, 1'b0, 99, 0, 1'b0);
        idle(4);
        chk("sat_sticky", int'(o_sat), 1);
        drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("sat_clear", int'(o_sat), 0);
        drive(127, 127, -127, 127, 1'b0, 1'b1, 1'b1, 1'b0, 127, 0, 1'b1);
        idle(1);
        drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        chk("sat_set_wins", int'(o_sat), 1);
        idle(2);
        drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("sat_clear_stalled", int'(o_sat), 0);

        // enable stall pattern 1,0,0,1,1,1,0,1 with hand-computed results
        drive(50, -20, 90, 90, 1'b0, 1'b1, 1'b1, 1'b0, 49, 21, 1'b0);
        drive(77, 77, 50, 50, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(77, 77, 50, 50, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(-128, -128, 0, 127, 1'b0, 1'b1, 1'b1, 1'b0, -127, -127, 1'b0);
        drive(10, 20, -128, 0, 1'b1, 1'b1, 1'b1, 1'b0, -20, 10, 1'b0);
        drive(-128, 0, 0, -128, 1'b0, 1'b1, 1'b1, 1'b0, 127, 0, 1'b1);
        drive(77, 77, 50, 50, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        drive(1, 1, 127, 127, 1'b0, 1'b1, 1'b1, 1'b0, 0, 2, 1'b0);
        for (int k = 0; k < 8; k++)
            drive(0, 0, 0, 0, 1'b0, 1'b0, k[0], 1'b0, 0, 0, 1'b0);
        idle(4);

        // reset mid-stream
        drive(50, -20, 90, 90, 1'b0, 1'b1, 1'b1, 1'b0, 49, 21, 1'b0);
        drive(1, 1, 127, 127, 1'b0, 1'b1, 1'b1, 1'b0, 0, 2, 1'b0);
        #1;
        i_reset = 1'b1;
        #1;
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_I", int'(o_dataI), 0);
        chk("midrst_Q", int'(o_dataQ), 0);
        chk("midrst_sat", int'(o_sat), 0);
        sb.delete();
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        drive(100, 0, 0, 127, 1'b0, 1'b1, 1'b1, 1'b0, 99, 0, 1'b0);
        chk("post_rst_valid_c1", int'(o_valid), 0);
        drive(100, 0, 0, 127, 1'b0, 1'b1, 1'b1, 1'b0, 99, 0, 1'b0);
        chk("post_rst_valid_c2", int'(o_valid), 0);
        drive(100, 0, 0, 127, 1'b0, 1'b1, 1'b1, 1'b0, 99, 0, 1'b0);
        chk("post_rst_valid_c3", int'(o_valid), 1);
        idle(4);

        // sweep against the golden model
        for (int n = 0; n < 4096; n++) begin
            ri    = int'($urandom_range(0, 255)) - 128;
            rq    = int'($urandom_range(0, 255)) - 128;
            idx   = int'($urandom_range(0, 63));
            rs    = sin_tab[idx];
            rc    = cos_tab[idx];
            rconj = 1'($urandom_range(0, 1));
            rv    = 1'($urandom_range(0, 3) != 0);
            ren   = 1'($urandom_range(0, 7) != 0);
            model(ri, rq, rs, rc, rconj, oi, oq, cl);
            drive(ri, rq, rs, rc, rconj, rv, ren, 1'b0, oi, oq, cl);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
